// File: rtl/overlay_gen.sv
// Crosshair and threshold-line overlay flags, aligned to the pixel pipeline by LATENCY cycles.
// Optional OVERLAY_BLINK_EN: blink the crosshair while the target is going stale.
module overlay_gen #(
    parameter int LATENCY      = 4,
    parameter int ARM_LEN      = 16,
    parameter int STALE_FRAMES = 8,
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720
) (
    input  logic        clk_pixel_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    input  logic        new_frame_in,
    input  logic [10:0] target_x_in,
    input  logic [9:0]  target_y_in,
    input  logic        target_valid_in,
    input  logic [9:0]  threshold_row_in,
    output logic        crosshair_out,
    output logic        line_pixel_out
);

    localparam int SW = $clog2(STALE_FRAMES + 1);
    localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_FRAMES);
    localparam logic [SW-1:0] STALE_HALF = SW'(STALE_FRAMES / 2);
    localparam logic [11:0]   ARM        = 12'(ARM_LEN);

    logic [10:0]        shadow_x, ax;
    logic [9:0]         shadow_y, ay, thr_row;
    logic               shadow_fresh, loaded, started;
    logic [SW-1:0]      stale_cnt;
    logic [LATENCY-1:0] xh_pipe, ln_pipe;

    // A coincident strobe wins shadow_fresh, so it goes live one frame later.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_fresh <= 1'b0;
        end else if (target_valid_in) begin
            shadow_x     <= target_x_in;
            shadow_y     <= target_y_in;
            shadow_fresh <= 1'b1;
        end else if (new_frame_in && shadow_fresh) begin
            shadow_fresh <= 1'b0;
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ax        <= '0;
            ay        <= '0;
            loaded    <= 1'b0;
            started   <= 1'b0;
            thr_row   <= '0;
            stale_cnt <= STALE_MAX;
        end else if (new_frame_in) begin
            started <= 1'b1;
            thr_row <= threshold_row_in;
            if (shadow_fresh) begin
                ax        <= shadow_x;
                ay        <= shadow_y;
                loaded    <= 1'b1;
                stale_cnt <= '0;
            end else if (stale_cnt < STALE_MAX) begin
                stale_cnt <= stale_cnt + 1'b1;
            end
        end
    end

    logic blink_hide;
`ifdef OVERLAY_BLINK_EN
    logic [2:0] frame_cnt;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_cnt <= '0;
        end else if (new_frame_in) begin
            frame_cnt <= frame_cnt + 3'd1;
        end
    end

    assign blink_hide = (stale_cnt >= STALE_HALF) && frame_cnt[2];
`else
    assign blink_hide = 1'b0;
`endif

    logic signed [11:0] dh, dv;
    logic [11:0]        adh, adv;
    logic               in_active, show, xh_raw, ln_raw;

    // Signed 12-bit differences keep arms near an edge from folding across the screen.
    always_comb begin
        dh        = $signed({1'b0, hcount_in}) - $signed({1'b0, ax});
        dv        = $signed({2'b00, vcount_in}) - $signed({2'b00, ay});
        adh       = dh[11] ? 12'(-dh) : 12'(dh);
        adv       = dv[11] ? 12'(-dv) : 12'(dv);
        in_active = data_valid_in && (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
        show      = loaded && (stale_cnt < STALE_MAX) && !blink_hide;
        xh_raw    = in_active && show &&
                    (((hcount_in == ax) && (adv <= ARM)) || ((vcount_in == ay) && (adh <= ARM)));
        ln_raw    = in_active && started && (thr_row < 10'(V_ACTIVE)) && (vcount_in == thr_row);
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            xh_pipe <= '0;
            ln_pipe <= '0;
        end else begin
            xh_pipe[0] <= xh_raw;
            ln_pipe[0] <= ln_raw;
            for (int i = 1; i < LATENCY; i++) begin
                xh_pipe[i] <= xh_pipe[i-1];
                ln_pipe[i] <= ln_pipe[i-1];
            end
        end
    end

    assign crosshair_out  = xh_pipe[LATENCY-1];
    assign line_pixel_out = ln_pipe[LATENCY-1];

endmodule

// File: tb/tb_overlay_gen.sv
// Directed self-checking bench for overlay_gen (default build, LATENCY=4, ARM_LEN=16).
`timescale 1ns/1ps
module tb_overlay_gen;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        data_valid, new_frame, target_valid;
    logic [10:0] target_x;
    logic [9:0]  target_y, threshold_row;
    logic        crosshair_out, line_pixel_out;

    int tests = 0;
    int fails = 0;
    int xh_count, ln_count, pos_err;

    // Hand-set expectations for the frame currently on screen.
    bit exp_vis, exp_thr_on;
    int exp_tx, exp_ty, exp_thr;
    bit xh_q[$];
    bit ln_q[$];

    always #5 clk = ~clk;

    overlay_gen dut (
        .clk_pixel_in    (clk),
        .rst_n_in        (rst_n),
        .hcount_in       (hcount),
        .vcount_in       (vcount),
        .data_valid_in   (data_valid),
        .new_frame_in    (new_frame),
        .target_x_in     (target_x),
        .target_y_in     (target_y),
        .target_valid_in (target_valid),
        .threshold_row_in(threshold_row),
        .crosshair_out   (crosshair_out),
        .line_pixel_out  (line_pixel_out)
    );

    function automatic bit exp_cross(input int h, input int v);
        int dh = (h > exp_tx) ? h - exp_tx : exp_tx - h;
        int dv = (v > exp_ty) ? v - exp_ty : exp_ty - v;
        return exp_vis && (((h == exp_tx) && (dv <= 16)) || ((v == exp_ty) && (dh <= 16)));
    endfunction

    // One pixel: sample outputs for inputs driven LAT cycles ago, then drive the next pixel.
    task automatic step(input int h, input int v, input bit dv);
        bit ex, el;
        @(negedge clk);
        ex = xh_q.pop_front();
        el = ln_q.pop_front();
        if (crosshair_out !== ex || line_pixel_out !== el) pos_err++;
        if (crosshair_out === 1'b1) xh_count++;
        if (line_pixel_out === 1'b1) ln_count++;
        hcount     = 11'(h);
        vcount     = 10'(v);
        data_valid = dv;
        xh_q.push_back(dv && exp_cross(h, v));
        ln_q.push_back(dv && exp_thr_on && (v == exp_thr));
    endtask

    task automatic scan(input int h0, input int h1, input int v0, input int v1);
        xh_count = 0;
        ln_count = 0;
        pos_err  = 0;
        xh_q.delete();
        ln_q.delete();
        for (int i = 0; i < LAT; i++) begin
            xh_q.push_back(1'b0);
            ln_q.push_back(1'b0);
        end
        for (int v = v0; v <= v1; v++)
            for (int h = h0; h <= h1; h++)
                step(h, v, 1'b1);
        for (int i = 0; i < LAT; i++) step(0, 0, 1'b0);
        xh_q.delete();
        ln_q.delete();
    endtask

    task automatic strobe(input int x, input int y);
        @(negedge clk);
        target_valid = 1'b1;
        target_x     = 11'(x);
        target_y     = 10'(y);
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    task automatic frame_pulse(input int thr, input bit stb, input int x, input int y);
        @(negedge clk);
        data_valid    = 1'b0;
        new_frame     = 1'b1;
        threshold_row = 10'(thr);
        target_valid  = stb;
        target_x      = 11'(x);
        target_y      = 10'(y);
        @(negedge clk);
        new_frame    = 1'b0;
        target_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hcount = '0; vcount = '0; data_valid = 1'b0; new_frame = 1'b0;
        target_valid = 1'b0; target_x = '0; target_y = '0; threshold_row = '0;
        #12;
        tests++;
        if (crosshair_out !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_xh: got %b expected 0", crosshair_out);
        end
        tests++;
        if (line_pixel_out !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_line: got %b expected 0", line_pixel_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_vis = 0; exp_thr_on = 0; exp_tx = 0; exp_ty = 0; exp_thr = 0;
        scan(0, 15, 0, 1);
        tests++;
        if (ln_count != 0 || xh_count != 0) begin
            fails++; $display("[TB] FAIL pre_frame_draw: got xh=%0d line=%0d expected 0/0", xh_count, ln_count);
        end
    endtask

    task automatic test_line();
        frame_pulse(100, 1'b0, 0, 0);
        exp_thr_on = 1; exp_thr = 100;
        scan(0, 1279, 100, 100);
        tests++;
        if (ln_count != 1280) begin
            fails++; $display("[TB] FAIL line_count: got %0d expected 1280", ln_count);
        end
        tests++;
        if (xh_count != 0 || pos_err != 0) begin
            fails++; $display("[TB] FAIL line_row: got xh=%0d pos_err=%0d expected 0/0", xh_count, pos_err);
        end
        scan(0, 31, 99, 99);
        tests++;
        if (ln_count != 0) begin
            fails++; $display("[TB] FAIL line_other_row: got %0d expected 0", ln_count);
        end
    endtask

    task automatic test_center();
        strobe(640, 360);
        frame_pulse(100, 1'b0, 0, 0);
        exp_vis = 1; exp_tx = 640; exp_ty = 360;
        scan(620, 660, 340, 380);
        tests++;
        if (xh_count != 65) begin
            fails++; $display("[TB] FAIL center_count: got %0d expected 65", xh_count);
        end
        tests++;
        if (pos_err != 0) begin
            fails++; $display("[TB] FAIL center_align: got %0d misplaced expected 0", pos_err);
        end
    endtask

    task automatic test_clip();
        strobe(5, 3);
        frame_pulse(100, 1'b0, 0, 0);
        exp_tx = 5; exp_ty = 3;
        scan(0, 30, 0, 25);
        tests++;
        if (xh_count != 41 || pos_err != 0) begin
            fails++; $display("[TB] FAIL clip_corner: got %0d pos_err=%0d expected 41/0", xh_count, pos_err);
        end
        scan(1260, 1279, 0, 5);
        tests++;
        if (xh_count != 0) begin
            fails++; $display("[TB] FAIL clip_hwrap: got %0d expected 0", xh_count);
        end
        scan(0, 10, 705, 719);
        tests++;
        if (xh_count != 0) begin
            fails++; $display("[TB] FAIL clip_vwrap: got %0d expected 0", xh_count);
        end
    endtask

    task automatic test_coincident();
        strobe(100, 200);
        frame_pulse(100, 1'b1, 640, 360);
        exp_tx = 100; exp_ty = 200;
        scan(80, 120, 180, 220);
        tests++;
        if (xh_count != 65 || pos_err != 0) begin
            fails++; $display("[TB] FAIL coincident_old: got %0d pos_err=%0d expected 65/0", xh_count, pos_err);
        end
        frame_pulse(100, 1'b0, 0, 0);
        exp_tx = 640; exp_ty = 360;
        scan(620, 660, 340, 380);
        tests++;
        if (xh_count != 65 || pos_err != 0) begin
            fails++; $display("[TB] FAIL coincident_new: got %0d pos_err=%0d expected 65/0", xh_count, pos_err);
        end
    endtask

    task automatic test_stale();
        for (int f = 1; f <= 8; f++) begin
            frame_pulse(100, 1'b0, 0, 0);
            exp_vis = (f < 8);
            scan(620, 660, 360, 360);
            tests++;
            if (xh_count != (f < 8 ? 33 : 0) || pos_err != 0) begin
                fails++;
                $display("[TB] FAIL stale_frame%0d: got %0d pos_err=%0d expected %0d/0",
                         f, xh_count, pos_err, (f < 8 ? 33 : 0));
            end
        end
        strobe(640, 360);
        frame_pulse(100, 1'b0, 0, 0);
        exp_vis = 1;
        scan(620, 660, 360, 360);
        tests++;
        if (xh_count != 33) begin
            fails++; $display("[TB] FAIL stale_restore: got %0d expected 33", xh_count);
        end
    endtask

    task automatic test_reset_midline();
        bit seen = 0;
        for (int h = 630; h <= 660 && !seen; h++) begin
            @(negedge clk);
            if (crosshair_out === 1'b1) seen = 1;
            else begin
                hcount = 11'(h); vcount = 10'd360; data_valid = 1'b1;
            end
        end
        tests++;
        if (!seen) begin
            fails++; $display("[TB] FAIL midline_wait: got no crosshair expected 1 within 31 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (crosshair_out !== 1'b0 || line_pixel_out !== 1'b0) begin
            fails++; $display("[TB] FAIL midline_reset: got %b%b expected 00", crosshair_out, line_pixel_out);
        end
        @(negedge clk);
        data_valid = 1'b0;
        rst_n = 1'b1;
        exp_vis = 0; exp_thr_on = 0;
        scan(620, 660, 360, 360);
        tests++;
        if (xh_count != 0) begin
            fails++; $display("[TB] FAIL post_reset_noframe: got %0d expected 0", xh_count);
        end
        frame_pulse(100, 1'b0, 0, 0);
        exp_thr_on = 1;
        scan(620, 660, 360, 360);
        tests++;
        if (xh_count != 0) begin
            fails++; $display("[TB] FAIL post_reset_notarget: got %0d expected 0", xh_count);
        end
        strobe(640, 360);
        frame_pulse(100, 1'b0, 0, 0);
        exp_vis = 1;
        scan(620, 660, 360, 360);
        tests++;
        if (xh_count != 33 || pos_err != 0) begin
            fails++; $display("[TB] FAIL post_reset_reload: got %0d pos_err=%0d expected 33/0", xh_count, pos_err);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_center();
        test_clip();
        test_coincident();
        test_stale();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
